tdc_capture_ctrl: RTL and testbench

TDC_CAPTURE_CTRL -- requirements
Module: tdc_capture_ctrl

---
 rtl/tdc_pkg.sv | 28 ++
 rtl/tdc_popcount.sv | 20 ++
 rtl/tdc_capture_ctrl.sv | 99 +++++++++
 tb/tb_tdc_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC capture controller.
// Holds the FSM states, default sizes and the fine-code width derivation.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONVERT,
        OUTPUT
    } tdc_state_t;

    localparam int NFF_DEFAULT = 32;
    localparam int CW_DEFAULT  = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int fw_of(input int nff);
        return clog2(nff + 1);
    endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational ones-count of a thermometer word.
// Counting ones rather than locating the edge tolerates bubbles.
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int NFF = NFF_DEFAULT,
    localparam int FW = fw_of(NFF)
) (
    input  logic [NFF-1:0] bits,
    output logic [FW-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NFF; i++) begin
            count = count + FW'(bits[i]);
        end
    end

endmodule

// File: rtl/tdc_capture_ctrl.sv
// TDC hit capture: coarse count plus popcount fine code,
// delivered over a valid/ready handshake with overflow detection.
module tdc_capture_ctrl
    import tdc_pkg::*;
#(
    parameter int NFF = NFF_DEFAULT,
    parameter int CW  = CW_DEFAULT,
    localparam int FW = fw_of(NFF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arm,
    input  logic [NFF-1:0] thermo,
    input  logic           out_ready,
    output logic           ts_valid,
    output logic [CW-1:0]  ts_coarse,
    output logic [FW-1:0]  ts_fine,
    output logic           busy,
    output logic           overflow
);

    tdc_state_t     state;
    tdc_state_t     state_nx;
    logic [CW-1:0]  cnt;
    logic [NFF-1:0] thermo_q;
    logic [NFF-1:0] cap;
    logic [FW-1:0]  pc;
    logic           hit;
    logic           sat;
    logic           enter_armed;

    tdc_popcount #(.NFF(NFF)) u_pc (
        .bits  (cap),
        .count (pc)
    );

    // Rising edge of the earliest tap; disarming wins over a hit.
    assign hit = (state == ARMED) && arm && !thermo_q[0] && thermo[0];
    assign sat = (cnt == '1);
    assign enter_armed = (state_nx == ARMED) && (state != ARMED);

    assign ts_valid = (state == OUTPUT);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        overflow = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                if (!arm) begin
                    state_nx = IDLE;
                end else if (hit) begin
                    state_nx = CONVERT;
                end else if (sat) begin
                    state_nx = IDLE;
                    overflow = 1'b1;
                end
            end
            CONVERT: begin
                state_nx = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) state_nx = arm ? ARMED : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            thermo_q  <= '0;
            cap       <= '0;
            ts_coarse <= '0;
            ts_fine   <= '0;
        end else begin
            state <= state_nx;
            if (enter_armed) begin
                cnt      <= '0;
                thermo_q <= thermo;
            end else if (state == ARMED) begin
                cnt      <= cnt + CW'(1);
                thermo_q <= thermo;
            end
            if (hit) begin
                cap       <= thermo;
                ts_coarse <= cnt;
            end
            if (state == CONVERT) ts_fine <= pc;
        end
    end

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Bench for tdc_capture_ctrl: CW=16 and CW=4 instances on shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_tdc_capture_ctrl;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [31:0] thermo;
    logic        out_ready;

    logic        ts_valid_a, busy_a, overflow_a;
    logic [15:0] ts_coarse_a;
    logic [5:0]  ts_fine_a;
    logic        ts_valid_b, busy_b, overflow_b;
    logic [3:0]  ts_coarse_b;
    logic [5:0]  ts_fine_b;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    bit mon_en   = 0;

    tdc_capture_ctrl #(.NFF(32), .CW(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .thermo    (thermo),
        .out_ready (out_ready),
        .ts_valid  (ts_valid_a),
        .ts_coarse (ts_coarse_a),
        .ts_fine   (ts_fine_a),
        .busy      (busy_a),
        .overflow  (overflow_a)
    );

    tdc_capture_ctrl #(.NFF(32), .CW(4)) u_ovf (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .thermo    (thermo),
        .out_ready (out_ready),
        .ts_valid  (ts_valid_b),
        .ts_coarse (ts_coarse_b),
        .ts_fine   (ts_fine_b),
        .busy      (busy_b),
        .overflow  (overflow_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ones(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n++;
        return n;
    endfunction

    // Model phases: 0 idle, 1 waiting for hit, 2 converting, 3 presenting.
    int          ph[2];
    int          cnt[2];
    int          coarse[2];
    int          fine[2];
    logic [31:0] prev[2];
    logic [31:0] cap[2];
    int          maxc[2];

    initial begin
        maxc[0] = 65535;
        maxc[1] = 15;
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; cnt[i] = 0; coarse[i] = 0; fine[i] = 0;
            prev[i] = 0; cap[i] = 0;
        end
    end

    task automatic step(input int i);
        bit h;
        if (!rst_n) begin
            ph[i] = 0; cnt[i] = 0; coarse[i] = 0; fine[i] = 0;
            prev[i] = 0; cap[i] = 0;
        end else begin
            case (ph[i])
                0: if (arm) begin
                    ph[i] = 1; cnt[i] = 0; prev[i] = thermo;
                end
                1: begin
                    h = arm && !prev[i][0] && thermo[0];
                    if (!arm) ph[i] = 0;
                    else if (h) begin
                        ph[i] = 2; cap[i] = thermo; coarse[i] = cnt[i];
                    end else if (cnt[i] == maxc[i]) ph[i] = 0;
                    prev[i] = thermo;
                    cnt[i] = (cnt[i] + 1) % (maxc[i] + 1);
                end
                2: begin
                    fine[i] = ones(cap[i]);
                    ph[i] = 3;
                end
                default: if (out_ready) begin
                    if (arm) begin
                        ph[i] = 1; cnt[i] = 0; prev[i] = thermo;
                    end else ph[i] = 0;
                end
            endcase
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && ts_valid_a && out_ready) xfers++;
        for (int i = 0; i < 2; i++) step(i);
    end

    always @(negedge clk) begin
        int ev, eo;
        int dv[2], db[2], dovf[2], dc[2], df[2];
        dv[0] = ts_valid_a; db[0] = busy_a; dovf[0] = overflow_a;
        dc[0] = ts_coarse_a; df[0] = ts_fine_a;
        dv[1] = ts_valid_b; db[1] = busy_b; dovf[1] = overflow_b;
        dc[1] = ts_coarse_b; df[1] = ts_fine_b;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                ev = (ph[i] == 3);
                eo = (ph[i] == 1) && arm && (cnt[i] == maxc[i])
                     && !(!prev[i][0] && thermo[0]);
                chk($sformatf("model%0d valid", i), dv[i], ev);
                chk($sformatf("model%0d busy", i), db[i], int'(ph[i] != 0));
                chk($sformatf("model%0d overflow", i), dovf[i], eo);
                chk($sformatf("model%0d coarse", i), dc[i], coarse[i]);
                chk($sformatf("model%0d fine", i), df[i], fine[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vcount, xb, vhit;
        rst_n = 0; arm = 0; thermo = 0; out_ready = 1;
        repeat (3) tick();
        rst_n = 1;
        mon_en = 1;
        @(negedge clk);
        chk("reset valid", ts_valid_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset coarse", ts_coarse_a, 0);
        chk("reset fine", ts_fine_a, 0);

        // basic measurement: hit on the 11th armed cycle
        tick();
        arm = 1;
        tick();
        repeat (10) tick();
        thermo = 32'h0000_FFFF;
        tick();
        tick();
        @(negedge clk);
        chk("basic valid", ts_valid_a, 1);
        chk("basic coarse", ts_coarse_a, 10);
        chk("basic fine", ts_fine_a, 16);
        chk("basic busy", busy_a, 1);
        chk("basic coarse cw4", ts_coarse_b, 10);
        tick();

        // backpressure with a bubbled code
        thermo = 0;
        out_ready = 0;
        tick();
        thermo = 32'h0000_00F7;
        tick();
        tick();
        xb = xfers;
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) out_ready = 1;
            @(negedge clk);
            if (ts_valid_a && ts_coarse_a == 16'd1 && ts_fine_a == 6'd7)
                vcount++;
            tick();
        end
        chk("bp stable valid cycles", vcount, 6);
        chk("bp transfers", xfers - xb, 1);
        @(negedge clk);
        chk("bp valid after", ts_valid_a, 0);
        chk("bp back armed", busy_a, 1);
        chk("bubble fine", ts_fine_a, 7);

        // all-ones code
        thermo = 0;
        tick();
        thermo = 32'hFFFF_FFFF;
        tick();
        tick();
        @(negedge clk);
        chk("allones valid", ts_valid_a, 1);
        chk("allones fine", ts_fine_a, 32);
        chk("allones coarse", ts_coarse_a, 1);
        tick();

        // saturation on the CW=4 instance
        thermo = 0;
        repeat (15) tick();
        @(negedge clk);
        chk("ovf pulse", overflow_b, 1);
        chk("ovf busy during", busy_b, 1);
        chk("ovf wide none", overflow_a, 0);
        tick();
        @(negedge clk);
        chk("ovf idle busy", busy_b, 0);
        chk("ovf pulse ends", overflow_b, 0);
        tick();
        repeat (15) tick();
        thermo = 32'h0000_0001;
        @(negedge clk);
        chk("hit at max no ovf", overflow_b, 0);
        tick();
        tick();
        @(negedge clk);
        chk("hit at max valid", ts_valid_b, 1);
        chk("hit at max coarse", ts_coarse_b, 15);
        chk("hit at max fine", ts_fine_b, 1);
        chk("wide coarse", ts_coarse_a, 32);
        tick();

        // reset while presenting
        thermo = 0;
        out_ready = 0;
        tick();
        thermo = 32'h0000_0003;
        tick();
        tick();
        @(negedge clk);
        chk("pre reset valid", ts_valid_a, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("post reset valid", ts_valid_a, 0);
        chk("post reset busy", busy_a, 0);
        chk("post reset coarse", ts_coarse_a, 0);
        chk("post reset fine", ts_fine_a, 0);
        chk("post reset valid cw4", ts_valid_b, 0);
        tick();
        @(negedge clk);
        chk("rearm busy", busy_a, 1);
        chk("rearm valid", ts_valid_a, 0);
        out_ready = 1;

        // disarm, then toggle the earliest tap
        arm = 0;
        tick();
        @(negedge clk);
        chk("disarm busy", busy_a, 0);
        vhit = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            thermo = (k % 2 == 0) ? 32'h0 : 32'h0000_00FF;
            @(negedge clk);
            vhit += int'(ts_valid_a) + int'(ts_valid_b);
        end
        chk("disarm no valid", vhit, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
